bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Clocked, multi-cycle converter from an 8-bit unsigned binary value to three BCD digits (hundreds, tens, ones). It uses the shift-and-add-3 (double-dabble) algorithm, one shift per clock. It feeds the seven-segment score and countdown display path, which consumes `Tens` and `Ones`. Results are held in registers, so the display sees stable digits between conversions.

## Interface
Parameters:
- None. Width is fixed at 8 input bits and 3 BCD digits.

Ports:
- `CLK`: input, 1 bit. System clock; all state changes on its rising edge.
- `RST_BTN`: input, 1 bit. One clock; reset is asynchronous and active-low.
- `binary`: input, 8 bits. Unsigned value to convert, 0–255.
- `start`: input, 1 bit. Conversion request, sampled only in IDLE.
- `busy`: output, 1 bit. High while a conversion is in progress.
- `done`: output, 1 bit. One-cycle pulse when new digits are loaded.
- `Hundreds`: output, 4 bits. BCD hundreds digit, 0–2.
- `Tens`: output, 4 bits. BCD tens digit, 0–9.
- `Ones`: output, 4 bits. BCD ones digit, 0–9.

## Operation
- FSM states: IDLE and SHIFT.
- IDLE with `start`=1:
  - Latch `binary` into the shift register.
  - Clear the 12-bit BCD scratch register and the counter.
  - Go to SHIFT.
- SHIFT, each cycle:
  - For each scratch nibble that is ≥5, add 3 (4-bit result, no carry between nibbles).
  - Shift the concatenation {scratch, shift register} left by one bit.
  - Increment the counter.
- After the 8th shift:
  - Copy the scratch nibbles to `Hundreds`, `Tens` and `Ones` in a single update, so the digits never show a mix of old and new values.
  - Assert `done`.
  - Return to IDLE.
- While in SHIFT, `binary` and `start` are ignored. Outputs hold the previous result until the update.
- Reset, including in the middle of a conversion:
  - Go to IDLE and abandon the conversion.
  - `busy`, `done`, `Hundreds`, `Tens` and `Ones` all go to 0.
  - The scratch register, shift register and counter clear.

## Timing
- `start` sampled high at rising edge k (in IDLE) puts the FSM in SHIFT; `busy` is high from edge k.
- Shifts occur at edges k+1 … k+8.
- At edge k+8:
  - the digits are loaded;
  - `done` rises and stays high for exactly one cycle, falling at edge k+9;
  - `busy` falls and the FSM returns to IDLE.
- Latency is 8 cycles from accept to result. The next `start` can be accepted at edge k+9, giving a sustained rate of one conversion per 9 cycles.
- Keeping `start` high continuously re-triggers a conversion each time the FSM is in IDLE.
- `done` and `busy` are never high in the same cycle after edge k+8.

## Configuration
- `BIN_TO_BCD_AUTO_EN`, when defined:
  - The `start` port is still present but ignored.
  - Every cycle spent in IDLE behaves as if `start`=1, so the converter continuously tracks `binary` with a new result every 9 cycles.
  - After reset release, the first conversion starts at the first rising edge.
- When not defined: conversions occur only on `start`, as described above.

## Structure
- Package `bin_to_bcd_pkg` holds:
  - the state enum (IDLE, SHIFT);
  - `BIN_W` = 8;
  - `BCD_DIGITS` = 3;
  - `ADJ_THRESH` = 5;
  - `ADJ_ADD` = 3.
- One combinational sub-module, `bcd_digit_adj`: 4-bit input and output; adds 3 when the input is ≥5, otherwise passes the input through. It is instantiated once per digit.
- The top level holds the FSM, the 3-bit shift counter, the scratch and shift registers, and the output registers.

## Test plan
- Reset: drive `RST_BTN`=0 asynchronously with no clock → all outputs 0; after release, `busy`=0 and `done`=0.
- Single conversion: `binary`=8'd47, `start` pulsed at edge k → `busy`=1 over edges k to k+8; at edge k+8, `Hundreds`/`Tens`/`Ones` = 0/4/7 and `done` is a one-cycle pulse.
- Boundaries: convert 0, 9, 10, 99, 100 and 255 → 0/0/0, 0/0/9, 0/1/0, 0/9/9, 1/0/0 and 2/5/5 respectively.
- Input change while busy: start with 8'd12, change `binary` to 8'd200 at k+3 → result 0/1/2; a new `start` raised during SHIFT is ignored.
- Reset mid-conversion: start with 8'd88, assert reset at k+4 → outputs 0 and FSM in IDLE; after release, a fresh `start` with 8'd88 → 0/8/8.
- Auto mode, with `BIN_TO_BCD_AUTO_EN` defined and `start` tied to 0: `binary`=8'd63 → `done` pulses every 9 cycles with 0/6/3; change `binary` to 8'd150 → 1/5/0 within 18 cycles.

Source files
------------

// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int BIN_W      = 8;
    localparam int BCD_DIGITS = 3;

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a nibble of 5 or more gets 3 added before
// the next shift so that the shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import bin_to_bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= ADJ_THRESH) ? (digit + ADJ_ADD) : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle 8-bit binary to 3-digit BCD converter, one shift per clock.
// Defining BIN_TO_BCD_AUTO_EN makes it restart on every idle cycle, ignoring start.
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_BTN,
    input  logic [BIN_W-1:0] binary,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [3:0]       Hundreds,
    output logic [3:0]       Tens,
    output logic [3:0]       Ones
);

    state_t                    state;
    logic [BIN_W-1:0]          shift_reg;
    logic [BCD_DIGITS*4-1:0]   scratch;
    logic [BCD_DIGITS*4-1:0]   scratch_adj;
    logic [BCD_DIGITS*4-1:0]   scratch_next;
    logic [2:0]                count;
    logic                      go;

`ifdef BIN_TO_BCD_AUTO_EN
    logic unused_start;
    assign unused_start = start;
    assign go           = 1'b1;
`else
    assign go           = start;
`endif

    for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (scratch[d*4 +: 4]),
            .adjusted (scratch_adj[d*4 +: 4])
        );
    end

    // Left shift of {scratch, shift_reg}: the binary MSB enters the ones digit.
    assign scratch_next = {scratch_adj[BCD_DIGITS*4-2:0], shift_reg[BIN_W-1]};

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            state     <= IDLE;
            shift_reg <= '0;
            scratch   <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            Hundreds  <= '0;
            Tens      <= '0;
            Ones      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (go) begin
                        shift_reg <= binary;
                        scratch   <= '0;
                        count     <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch   <= scratch_next;
                    shift_reg <= {shift_reg[BIN_W-2:0], 1'b0};
                    count     <= count + 3'd1;
                    // All three digits update together on the final shift.
                    if (count == 3'(BIN_W - 1)) begin
                        Hundreds <= scratch_next[11:8];
                        Tens     <= scratch_next[7:4];
                        Ones     <= scratch_next[3:0];
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq; covers start-driven mode,
// or auto mode when BIN_TO_BCD_AUTO_EN is defined.
module tb_bin_to_bcd_seq;

    logic       CLK;
    logic       RST_BTN;
    logic [7:0] binary;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] Hundreds;
    logic [3:0] Tens;
    logic [3:0] Ones;

    logic        clk_run;
    int          vectors;
    int          miscompares;
    logic [11:0] prev_digits;

    bin_to_bcd_seq dut (
        .CLK      (CLK),
        .RST_BTN  (RST_BTN),
        .binary   (binary),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .Hundreds (Hundreds),
        .Tens     (Tens),
        .Ones     (Ones)
    );

    initial begin
        CLK = 1'b0;
        wait (clk_run);
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string tag, input logic [11:0] observed,
                               input logic [11:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One conversion with full cycle checks; optional input disturbances mid-SHIFT.
    task automatic applyStimulus(input logic [7:0] value, input logic [11:0] expected,
                                 input int change_step, input logic [7:0] change_value,
                                 input int restart_on, input int restart_off);
        @(negedge CLK);
        binary = value;
        start  = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        checkOutput("accept_busy_done", {10'd0, busy, done}, 12'b10);
        checkOutput("accept_hold", {Hundreds, Tens, Ones}, prev_digits);
        for (int i = 1; i <= 8; i++) begin
            @(posedge CLK);
            #1;
            if (i < 8) begin
                checkOutput("shift_busy_done", {10'd0, busy, done}, 12'b10);
                checkOutput("shift_hold", {Hundreds, Tens, Ones}, prev_digits);
            end else begin
                checkOutput("final_busy_done", {10'd0, busy, done}, 12'b01);
                checkOutput("final_digits", {Hundreds, Tens, Ones}, expected);
            end
            if (i == change_step) binary = change_value;
            if (i == restart_on)  start = 1'b1;
            if (i == restart_off) start = 1'b0;
        end
        @(posedge CLK);
        #1;
        checkOutput("after_busy_done", {10'd0, busy, done}, 12'b00);
        checkOutput("after_digits", {Hundreds, Tens, Ones}, expected);
        prev_digits = expected;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        prev_digits = 12'h000;
        clk_run     = 1'b0;
        RST_BTN     = 1'b1;
        binary      = 8'd0;
        start       = 1'b0;

        #2 RST_BTN = 1'b0;
        #1;
        checkOutput("reset_digits", {Hundreds, Tens, Ones}, 12'h000);
        checkOutput("reset_busy_done", {10'd0, busy, done}, 12'b00);

        clk_run = 1'b1;
        repeat (2) @(posedge CLK);

`ifdef BIN_TO_BCD_AUTO_EN
        begin
            int  found;
            binary = 8'd63;
            @(negedge CLK);
            RST_BTN = 1'b1;
            found = 0;
            for (int i = 0; i < 12 && found == 0; i++) begin
                @(posedge CLK);
                #1;
                if (done) found = 1;
            end
            checkOutput("auto_first_done", 12'(found), 12'd1);
            checkOutput("auto_first_digits", {Hundreds, Tens, Ones}, 12'h063);
            repeat (9) @(posedge CLK);
            #1;
            checkOutput("auto_period_done", {11'd0, done}, 12'd1);
            checkOutput("auto_period_digits", {Hundreds, Tens, Ones}, 12'h063);
            binary = 8'd150;
            found = 0;
            for (int i = 0; i < 18 && found == 0; i++) begin
                @(posedge CLK);
                #1;
                if (done && {Hundreds, Tens, Ones} == 12'h150) found = 1;
            end
            checkOutput("auto_track_150", 12'(found), 12'd1);
        end
`else
        @(negedge CLK);
        RST_BTN = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("release_busy_done", {10'd0, busy, done}, 12'b00);

        applyStimulus(8'd47,  12'h047, 0, 8'd0, 0, 0);
        applyStimulus(8'd0,   12'h000, 0, 8'd0, 0, 0);
        applyStimulus(8'd9,   12'h009, 0, 8'd0, 0, 0);
        applyStimulus(8'd10,  12'h010, 0, 8'd0, 0, 0);
        applyStimulus(8'd99,  12'h099, 0, 8'd0, 0, 0);
        applyStimulus(8'd100, 12'h100, 0, 8'd0, 0, 0);
        applyStimulus(8'd255, 12'h255, 0, 8'd0, 0, 0);

        // binary changes and start re-raised while shifting must not disturb the result
        applyStimulus(8'd12,  12'h012, 3, 8'd200, 5, 7);

        @(negedge CLK);
        binary = 8'd88;
        start  = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        RST_BTN = 1'b0;
        #1;
        checkOutput("midreset_digits", {Hundreds, Tens, Ones}, 12'h000);
        checkOutput("midreset_busy_done", {10'd0, busy, done}, 12'b00);
        @(negedge CLK);
        RST_BTN = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("midreset_idle", {10'd0, busy, done}, 12'b00);
        prev_digits = 12'h000;
        applyStimulus(8'd88,  12'h088, 0, 8'd0, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
